// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers pixel coordinates, measures line/frame periods and locks to the expected raster.
// rx_* are combinational from the counters and aligned with s_rgb; no backpressure, one sample per p_tick.
module vga_rx_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_OFFSET    = 144,
  parameter int V_OFFSET    = 35,
  parameter int H_DISP      = 640,
  parameter int V_DISP      = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  input  logic       err_clr,
  output logic [9:0] rx_x,
  output logic [9:0] rx_y,
  output logic       rx_video_on,
  output logic       locked,
  output logic [9:0] h_period,
  output logic [9:0] v_period,
  output logic [7:0] frame_count,
  output logic [2:0] probe_rgb,
  output logic       probe_valid,
  output logic       err_h,
  output logic       err_v
);
  typedef enum logic [1:0] {UNLOCK, CHECK, LOCKED} state_t;

  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0]  H_OFF   = 10'(H_OFFSET);
  localparam logic [9:0]  H_END   = 10'(H_OFFSET + H_DISP);
  localparam logic [9:0]  V_OFF   = 10'(V_OFFSET);
  localparam logic [9:0]  V_END   = 10'(V_OFFSET + V_DISP);
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX = 10'd1023;

  state_t      state, state_nxt;
  logic [2:0]  good_cnt, good_nxt;
  logic        s_hs, s_vs, d_hs, d_vs;
  logic [2:0]  s_rgb;
  logic [9:0]  hcnt, vcnt, vcnt_line;
  logic [10:0] h_len;
  logic        line_bad, line_bad_eff;
  logic        h_fall, v_fall, h_bad, frame_good, h_sat, v_sat;
  logic        set_err_h, set_err_v, fc_inc;
  logic        in_h, in_v, cap;

  assign h_fall = p_tick & d_hs & ~s_hs;
  assign v_fall = p_tick & d_vs & ~s_vs;
  assign h_len  = {1'b0, hcnt} + 11'd1;
  assign h_bad  = h_fall & (h_len != H_TOT);

  // Line is folded in before the frame so a coincident hsync/vsync fall counts its own line.
  assign vcnt_line    = (h_fall && vcnt != CNT_MAX) ? vcnt + 10'd1 : vcnt;
  assign line_bad_eff = line_bad | h_bad;
  assign frame_good   = (vcnt_line == V_TOT) & ~line_bad_eff;

  // Fire on the tick that moves a counter into saturation.
  assign h_sat = p_tick & ~h_fall & (hcnt == CNT_MAX - 10'd1);
  assign v_sat = h_fall & ~v_fall & (vcnt == CNT_MAX - 10'd1);

  assign locked      = (state == LOCKED);
  assign in_h        = (hcnt >= H_OFF) && (hcnt < H_END);
  assign in_v        = (vcnt >= V_OFF) && (vcnt < V_END);
  assign rx_video_on = locked & in_h & in_v;
  assign rx_x        = rx_video_on ? hcnt - H_OFF : '0;
  assign rx_y        = rx_video_on ? vcnt - V_OFF : '0;
  assign cap         = p_tick & rx_video_on & (rx_x == probe_x) & (rx_y == probe_y);

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    set_err_h = h_sat;
    set_err_v = v_sat;
    fc_inc    = 1'b0;
    case (state)
      UNLOCK: begin
        if (v_fall) begin
          state_nxt = CHECK;
          good_nxt  = '0;
        end
      end
      CHECK: begin
        if (v_fall) begin
          if (frame_good) begin
            good_nxt = good_cnt + 3'd1;
            if (good_cnt + 3'd1 == LOCK_N) state_nxt = LOCKED;
          end else begin
            good_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (h_bad) begin
          set_err_h = 1'b1;
          state_nxt = UNLOCK;
        end
        if (v_fall && vcnt_line != V_TOT) begin
          set_err_v = 1'b1;
          state_nxt = UNLOCK;
        end
        fc_inc = v_fall & frame_good;
      end
      default: state_nxt = UNLOCK;
    endcase
    if (h_sat || v_sat) state_nxt = UNLOCK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= UNLOCK;
      good_cnt    <= '0;
      s_hs        <= 1'b0;
      s_vs        <= 1'b0;
      d_hs        <= 1'b0;
      d_vs        <= 1'b0;
      s_rgb       <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      line_bad    <= 1'b0;
      h_period    <= '0;
      v_period    <= '0;
      frame_count <= '0;
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
    end else begin
      state       <= state_nxt;
      good_cnt    <= good_nxt;
      probe_valid <= cap;
      if (p_tick) begin
        s_hs  <= hsync;
        s_vs  <= vsync;
        d_hs  <= s_hs;
        d_vs  <= s_vs;
        s_rgb <= rgb;
        if (h_fall)               hcnt <= '0;
        else if (hcnt != CNT_MAX) hcnt <= hcnt + 10'd1;
        vcnt <= v_fall ? '0 : vcnt_line;
      end
      if (h_fall) h_period <= h_len[9:0];
      if (v_fall) v_period <= vcnt_line;
      if (v_fall)     line_bad <= 1'b0;
      else if (h_bad) line_bad <= 1'b1;
      if (fc_inc) frame_count <= frame_count + 8'd1;
      if (cap) probe_rgb <= s_rgb;
      if (set_err_h)    err_h <= 1'b1;
      else if (err_clr) err_h <= 1'b0;
      if (set_err_v)    err_v <= 1'b1;
      else if (err_clr) err_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a scaled-down raster (16x10 total, 12x6 active) to keep runs short.
module tb_vga_rx_monitor;
  localparam int HT = 16, VT = 10, HO = 3, VO = 2, HD = 12, VD = 6, LF = 2;
  localparam int HSW = 2, VSW = 1;

  logic       clk = 1'b0;
  logic       reset, p_tick, hsync, vsync, err_clr;
  logic [2:0] rgb;
  logic [9:0] probe_x, probe_y;
  logic [9:0] rx_x, rx_y, h_period, v_period;
  logic       rx_video_on, locked, probe_valid, err_h, err_v;
  logic [7:0] frame_count;
  logic [2:0] probe_rgb;

  always #5 clk = ~clk;

  vga_rx_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_OFFSET(HO), .V_OFFSET(VO),
    .H_DISP(HD), .V_DISP(VD), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .probe_x(probe_x), .probe_y(probe_y), .err_clr(err_clr),
    .rx_x(rx_x), .rx_y(rx_y), .rx_video_on(rx_video_on), .locked(locked),
    .h_period(h_period), .v_period(v_period), .frame_count(frame_count),
    .probe_rgb(probe_rgb), .probe_valid(probe_valid), .err_h(err_h), .err_v(err_v)
  );

  typedef struct {
    int nlines; int long_len; int px; int py; bit clr;
    int locked; int err_h; int err_v; int hp; int vp; int fc;
    int pulses; int prgb; int act; int unlocks; int ul_hp; int ul_vp; int ul_err;
  } vec_t;

  vec_t vt[13];
  int   n_chk = 0, n_pass = 0;
  int   tick_div = 2;
  int   act_cnt = 0, pulse_cnt = 0, unlock_cnt = 0, ul_hp = 0, ul_vp = 0, ul_err = 0;
  int   fc_max = 0, x_max = 0, y_max = 0, bad_xy = 0;
  logic prev_locked = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic observe();
    if (p_tick && rx_video_on) act_cnt++;
    if (probe_valid) pulse_cnt++;
    if (rx_video_on) begin
      if (int'(rx_x) > x_max) x_max = int'(rx_x);
      if (int'(rx_y) > y_max) y_max = int'(rx_y);
      if (int'(rx_x) >= HD || int'(rx_y) >= VD) bad_xy++;
    end else if (rx_x != 10'd0 || rx_y != 10'd0) begin
      bad_xy++;
    end
    if (prev_locked && !locked) begin
      unlock_cnt++;
      ul_hp  = int'(h_period);
      ul_vp  = int'(v_period);
      ul_err = int'({err_h, err_v});
    end
    prev_locked = locked;
    if (int'(frame_count) > fc_max) fc_max = int'(frame_count);
  endtask

  task automatic step(input logic tk, input logic hs, input logic vs, input logic [2:0] c);
    @(negedge clk);
    observe();
    p_tick = tk;
    hsync  = hs;
    vsync  = vs;
    rgb    = c;
  endtask

  // rgb is offset so that the sample landing at rx_x=k carries k[2:0].
  task automatic pix(input int h, input int l);
    logic [2:0] c;
    c = 3'(h - HO - 1);
    step(1'b1, h >= HSW, l >= VSW, c);
    for (int i = 1; i < tick_div; i++) step(1'b0, h >= HSW, l >= VSW, c);
  endtask

  // Frame runs from pixel HSW of line 0 through pixels 0..1 of the next frame, so it ends on its vsync fall.
  task automatic run_frame(input int nlines, input int long_line, input int long_len, input int rst_line);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == long_line) ? long_len : HT;
      for (int h = (l == 0) ? HSW : 0; h < len; h++) begin
        if (l == rst_line && h == 4) begin
          @(negedge clk);
          reset = 1'b0;
          #1;
          check("reset_mid_frame_outputs_zero",
                int'(|{rx_x, rx_y, rx_video_on, locked, h_period, v_period, frame_count,
                       probe_rgb, probe_valid, err_h, err_v}), 0);
        end
        if (l == rst_line && h == 8) reset = 1'b1;
        pix(h, l);
      end
    end
    pix(0, 0);
    pix(1, 0);
    step(1'b0, 1'b0, 1'b0, rgb);
  endtask

  task automatic clear_err();
    step(1'b0, hsync, vsync, rgb);
    err_clr = 1'b1;
    step(1'b0, hsync, vsync, rgb);
    err_clr = 1'b0;
  endtask

  task automatic mon_clear();
    act_cnt = 0; pulse_cnt = 0; unlock_cnt = 0; ul_hp = 0; ul_vp = 0; ul_err = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1);
  end

  initial begin
    // nlines long_len px py clr | locked eh ev hp vp fc pulses prgb act unlocks ul_hp ul_vp ul_err
    vt[0]  = '{10, 16,  10, 4, 1'b0, 0, 0, 0, 16, 10, 0, 0, 0,  0, 0,  0,  0, 0};
    vt[1]  = '{10, 16,  10, 4, 1'b0, 0, 0, 0, 16, 10, 0, 0, 0,  0, 0,  0,  0, 0};
    vt[2]  = '{10, 16,  10, 4, 1'b0, 1, 0, 0, 16, 10, 0, 0, 0,  0, 0,  0,  0, 0};
    vt[3]  = '{10, 16,  10, 4, 1'b0, 1, 0, 0, 16, 10, 1, 1, 2, 72, 0,  0,  0, 0};
    vt[4]  = '{10, 16, 700, 4, 1'b0, 1, 0, 0, 16, 10, 2, 0, 2, 72, 0,  0,  0, 0};
    vt[5]  = '{10, 17,   5, 1, 1'b0, 0, 1, 0, 16, 10, 2, 1, 5, 24, 1, 17, 10, 2};
    vt[6]  = '{10, 16,  10, 4, 1'b0, 0, 1, 0, 16, 10, 2, 0, 5,  0, 0,  0,  0, 0};
    vt[7]  = '{10, 16,  10, 4, 1'b0, 1, 1, 0, 16, 10, 2, 0, 5,  0, 0,  0,  0, 0};
    vt[8]  = '{10, 16,  10, 4, 1'b1, 1, 0, 0, 16, 10, 3, 1, 2, 72, 0,  0,  0, 0};
    vt[9]  = '{ 9, 16,  10, 4, 1'b0, 0, 0, 1, 16,  9, 3, 1, 2, 72, 1, 16,  9, 1};
    vt[10] = '{10, 16,  10, 4, 1'b1, 0, 0, 0, 16, 10, 3, 0, 2,  0, 0,  0,  0, 0};
    vt[11] = '{10, 16,  10, 4, 1'b0, 0, 0, 0, 16, 10, 3, 0, 2,  0, 0,  0,  0, 0};
    vt[12] = '{10, 16,  10, 4, 1'b0, 1, 0, 0, 16, 10, 3, 0, 2,  0, 0,  0,  0, 0};

    reset = 1'b0; p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0;
    err_clr = 1'b0; probe_x = 10'd10; probe_y = 10'd4;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs_zero",
          int'(|{rx_x, rx_y, rx_video_on, locked, h_period, v_period, frame_count,
                 probe_rgb, probe_valid, err_h, err_v}), 0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      probe_x = 10'(vt[i].px);
      probe_y = 10'(vt[i].py);
      if (vt[i].clr) clear_err();
      mon_clear();
      run_frame(vt[i].nlines, 3, vt[i].long_len, -1);
      check($sformatf("row%0d_locked", i),      int'(locked),      vt[i].locked);
      check($sformatf("row%0d_err_h", i),       int'(err_h),       vt[i].err_h);
      check($sformatf("row%0d_err_v", i),       int'(err_v),       vt[i].err_v);
      check($sformatf("row%0d_h_period", i),    int'(h_period),    vt[i].hp);
      check($sformatf("row%0d_v_period", i),    int'(v_period),    vt[i].vp);
      check($sformatf("row%0d_frame_count", i), int'(frame_count), vt[i].fc);
      check($sformatf("row%0d_probe_pulses", i), pulse_cnt,        vt[i].pulses);
      check($sformatf("row%0d_probe_rgb", i),   int'(probe_rgb),   vt[i].prgb);
      check($sformatf("row%0d_active_ticks", i), act_cnt,          vt[i].act);
      check($sformatf("row%0d_unlocks", i),     unlock_cnt,        vt[i].unlocks);
      if (vt[i].unlocks != 0) begin
        check($sformatf("row%0d_h_period_at_unlock", i), ul_hp,  vt[i].ul_hp);
        check($sformatf("row%0d_v_period_at_unlock", i), ul_vp,  vt[i].ul_vp);
        check($sformatf("row%0d_errs_at_unlock", i),     ul_err, vt[i].ul_err);
      end
    end
    check("rx_x_max", x_max, HD - 1);
    check("rx_y_max", y_max, VD - 1);
    check("rx_xy_range_and_zero_outside", bad_xy, 0);

    // Reset mid-frame while locked, then relock on the third vsync fall after release.
    run_frame(VT, -1, HT, 5);
    check("after_reset_vfall1_locked", int'(locked), 0);
    run_frame(VT, -1, HT, -1);
    check("after_reset_vfall2_locked", int'(locked), 0);
    run_frame(VT, -1, HT, -1);
    check("after_reset_vfall3_locked", int'(locked), 1);
    check("after_reset_h_period", int'(h_period), HT);
    check("after_reset_v_period", int'(v_period), VT);
    check("after_reset_frame_count", int'(frame_count), 0);

    // Long locked run at full tick rate: frame_count must pass 255 and wrap to 0.
    tick_div = 1;
    fc_max = 0;
    for (int f = 0; f < 256; f++) run_frame(VT, -1, HT, -1);
    check("wrap_frame_count_max", fc_max, 255);
    check("wrap_frame_count", int'(frame_count), 0);
    check("wrap_still_locked", int'(locked), 1);

    // Stuck hsync: hcnt climbs from 0; the error lands on the tick reaching 1023.
    for (int i = 0; i < 1022; i++) step(1'b1, 1'b1, 1'b1, 3'd0);
    step(1'b0, 1'b1, 1'b1, 3'd0);
    check("stuck_1022_locked", int'(locked), 1);
    check("stuck_1022_err_h", int'(err_h), 0);
    step(1'b1, 1'b1, 1'b1, 3'd0);
    step(1'b0, 1'b1, 1'b1, 3'd0);
    check("stuck_1023_err_h", int'(err_h), 1);
    check("stuck_1023_locked", int'(locked), 0);
    check("stuck_1023_err_v", int'(err_v), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
